// File: rtl/uart_line_arbiter.sv
// Round-robin arbiter that gives one requester at a time a whole line on a shared UART byte stream.
// A newline is forced when a line reaches LINE_MAX bytes or when its owner stalls too long.
module uart_line_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LINE_MAX     = 132,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arb_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 grant_active,
    output logic [2:0]           grant_id,
    output logic                 timeout_pulse,
    output logic [15:0]          lines_done
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(LINE_MAX + 1);
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [7:0]    NEWLINE   = 8'h0A;
    localparam logic [BW-1:0] LINE_LAST = BW'(LINE_MAX - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_INSERT_NL
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_grant_q, last_grant_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [15:0]   lines_done_q, lines_done_d;

    logic [7:0]    req_bytes [NUM_REQ];
    logic [OW-1:0] above_idx, any_idx, win_idx;
    logic          above_found;
    logic [15:0]   lines_inc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index.
    always_comb begin
        above_found = 1'b0;
        above_idx   = '0;
        any_idx     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                any_idx = OW'(j);
                if (OW'(j) > last_grant_q) begin
                    above_found = 1'b1;
                    above_idx   = OW'(j);
                end
            end
        end
    end

    assign win_idx   = above_found ? above_idx : any_idx;
    assign lines_inc = (lines_done_q == 16'hFFFF) ? lines_done_q : lines_done_q + 16'd1;

    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        lines_done_d  = lines_done_q;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        req_ready     = '0;
        timeout_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_en && (|req_valid)) begin
                    state_d      = ST_LOCKED;
                    owner_d      = win_idx;
                    last_grant_d = win_idx;
                    byte_cnt_d   = '0;
                    idle_cnt_d   = '0;
                end
            end

            ST_LOCKED: begin
                tx_valid = req_valid[owner_q];
                tx_data  = tx_valid ? req_bytes[owner_q] : 8'h00;
                for (int j = 0; j < NUM_REQ; j++) begin
                    req_ready[j] = tx_ready && (OW'(j) == owner_q);
                end

                if (tx_valid && tx_ready) begin
                    if (tx_data == NEWLINE) begin
                        state_d      = ST_IDLE;
                        lines_done_d = lines_inc;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        idle_cnt_d = '0;
                        if (byte_cnt_q == LINE_LAST) begin
                            state_d = ST_INSERT_NL;
                        end
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    // An empty line is simply dropped; a partial one is closed with a newline.
                    timeout_pulse = 1'b1;
                    state_d       = (byte_cnt_q == '0) ? ST_IDLE : ST_INSERT_NL;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            ST_INSERT_NL: begin
                tx_valid = 1'b1;
                tx_data  = NEWLINE;
                if (tx_ready) begin
                    state_d      = ST_IDLE;
                    lines_done_d = lines_inc;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_grant_q <= LAST_REQ;
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            lines_done_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            lines_done_q <= lines_done_d;
        end
    end

    assign grant_active = (state_q != ST_IDLE);
    assign grant_id     = 3'(owner_q);
    assign lines_done   = lines_done_q;

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Bench for uart_line_arbiter: directed line scenarios plus random traffic, all checked
// cycle by cycle against a line-level reference model of the arbiter.
module tb_uart_line_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int LINE_MAX     = 132;
    localparam int IDLE_TIMEOUT = 1024;
    localparam logic [7:0] NL   = 8'h0A;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic                 grant_active;
    logic [2:0]           grant_id;
    logic                 timeout_pulse;
    logic [15:0]          lines_done;

    uart_line_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LINE_MAX     (LINE_MAX),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arb_en        (arb_en),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_active  (grant_active),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse),
        .lines_done    (lines_done)
    );

    always #5 clk = ~clk;

    // Pending bytes per requester; a requester is valid when enabled and its queue is non-empty.
    logic [7:0] src_q [NUM_REQ][$];
    bit         src_en [NUM_REQ];

    // Reference model: owner is -1 while the line is free.
    int m_owner, m_last, m_gid, m_len, m_stall, m_lines;
    bit m_nl;

    int n_checks = 0;
    int n_errors = 0;
    int tmo_seen, nl_seen;
    int grants_seen[$];
    bit prev_active;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int grant_at(input int k);
        return (k < grants_seen.size()) ? grants_seen[k] : -1;
    endfunction

    task automatic push_str(input int r, input string s);
        for (int i = 0; i < s.len(); i++) src_q[r].push_back(s[i]);
    endtask

    task automatic push_rand_line(input int r);
        int len;
        logic [7:0] b;
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == NL) b = 8'h41;
            src_q[r].push_back(b);
        end
        if ($urandom_range(0, 9) != 0) src_q[r].push_back(NL);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = src_en[i] && (src_q[i].size() > 0);
            req_data[8*i +: 8] = req_valid[i] ? src_q[i][0] : 8'($urandom);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        int nx_owner, nx_last, nx_gid, nx_len, nx_stall, nx_lines, pop_idx, c;
        bit nx_nl, e_valid, e_tmo;
        logic [7:0] e_data;
        logic [NUM_REQ-1:0] e_ready;

        drive_inputs();
        @(negedge clk);
        nx_owner = m_owner; nx_last = m_last; nx_gid = m_gid; nx_len = m_len;
        nx_stall = m_stall; nx_lines = m_lines; nx_nl = m_nl;
        e_valid = 1'b0; e_data = 8'h00; e_ready = '0; e_tmo = 1'b0; pop_idx = -1;

        if (m_owner >= 0 && m_nl) begin
            e_valid = 1'b1;
            e_data  = NL;
            if (tx_ready) begin
                nx_nl = 1'b0; nx_owner = -1; nx_lines = sat_inc(m_lines);
            end
        end else if (m_owner >= 0) begin
            e_valid = req_valid[m_owner];
            if (e_valid) e_data = src_q[m_owner][0];
            e_ready[m_owner] = tx_ready;
            if (e_valid && tx_ready) begin
                pop_idx = m_owner;
                if (e_data == NL) begin
                    nx_owner = -1; nx_lines = sat_inc(m_lines);
                end else begin
                    nx_len = m_len + 1; nx_stall = 0;
                    if (nx_len == LINE_MAX) nx_nl = 1'b1;
                end
            end else begin
                nx_stall = m_stall + 1;
                if (nx_stall == IDLE_TIMEOUT) begin
                    e_tmo = 1'b1;
                    if (m_len == 0) nx_owner = -1;
                    else nx_nl = 1'b1;
                end
            end
        end else if (arb_en && req_valid != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (m_last + k) % NUM_REQ;
                if (nx_owner < 0 && req_valid[c]) begin
                    nx_owner = c; nx_last = c; nx_gid = c; nx_len = 0; nx_stall = 0;
                end
            end
        end

        check("tx_valid", 32'(tx_valid), 32'(e_valid));
        check("tx_data", 32'(tx_data), 32'(e_data));
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("grant_active", 32'(grant_active), 32'(m_owner >= 0));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("timeout_pulse", 32'(timeout_pulse), 32'(e_tmo));
        check("lines_done", 32'(lines_done), 32'(m_lines));

        if (grant_active && !prev_active) grants_seen.push_back(int'(grant_id));
        prev_active = grant_active;
        if (timeout_pulse) tmo_seen++;
        if (tx_valid && tx_ready && tx_data == NL) nl_seen++;

        @(posedge clk);
        m_owner = nx_owner; m_last = nx_last; m_gid = nx_gid; m_len = nx_len;
        m_stall = nx_stall; m_lines = nx_lines; m_nl = nx_nl;
        if (pop_idx >= 0) void'(src_q[pop_idx].pop_front());
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, and leaves arb_en low.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset  = 1'b1;
        arb_en = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_active", 32'(grant_active), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
        check("rst_lines_done", 32'(lines_done), 32'd0);
        m_owner = -1; m_last = NUM_REQ - 1; m_gid = 0; m_len = 0;
        m_stall = 0; m_lines = 0; m_nl = 1'b0;
        prev_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; arb_en = 1'b0; tx_ready = 1'b0;
        req_valid = '0; req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) src_en[i] = 1'b1;
        repeat (2) @(posedge clk);
        apply_reset();

        // Two requesters after reset: lowest index first, then the other.
        grants_seen.delete();
        push_str(0, "AB\n");
        push_str(2, "C\n");
        arb_en = 1'b1; tx_ready = 1'b1;
        run(12);
        check("ab_first_grant", 32'(grant_at(0)), 32'd0);
        check("ab_second_grant", 32'(grant_at(1)), 32'd2);
        check("ab_lines", 32'(lines_done), 32'd2);

        // Four requesters sending one-byte lines rotate 0,1,2,3,0,...
        apply_reset();
        grants_seen.delete();
        for (int r = 0; r < NUM_REQ; r++) push_str(r, "\n\n");
        arb_en = 1'b1; tx_ready = 1'b1;
        run(20);
        for (int k = 0; k < 2 * NUM_REQ; k++) check("rr_order", 32'(grant_at(k)), 32'(k % NUM_REQ));
        check("rr_lines", 32'(lines_done), 32'd8);

        // Overlong line gets a forced newline.
        apply_reset();
        nl_seen = 0; tmo_seen = 0;
        for (int i = 0; i < LINE_MAX; i++) src_q[1].push_back(8'h41);
        arb_en = 1'b1; tx_ready = 1'b1;
        run(LINE_MAX + 8);
        check("max_nl_count", 32'(nl_seen), 32'd1);
        check("max_lines", 32'(lines_done), 32'd1);
        check("max_released", 32'(grant_active), 32'd0);

        // Stalled owner with a partial line: timeout then inserted newline.
        apply_reset();
        nl_seen = 0; tmo_seen = 0;
        push_str(3, "HELLO");
        arb_en = 1'b1; tx_ready = 1'b1;
        run(IDLE_TIMEOUT + 20);
        check("tmo_partial_pulses", 32'(tmo_seen), 32'd1);
        check("tmo_partial_nl", 32'(nl_seen), 32'd1);
        check("tmo_partial_lines", 32'(lines_done), 32'd1);

        // Stalled owner with an empty line: timeout straight back to idle.
        nl_seen = 0; tmo_seen = 0;
        push_str(3, "Z");
        run(1);
        src_en[3] = 1'b0;
        run(IDLE_TIMEOUT + 5);
        check("tmo_empty_pulses", 32'(tmo_seen), 32'd1);
        check("tmo_empty_nl", 32'(nl_seen), 32'd0);
        check("tmo_empty_lines", 32'(lines_done), 32'd1);
        check("tmo_empty_released", 32'(grant_active), 32'd0);
        src_q[3].delete();
        src_en[3] = 1'b1;

        // Random traffic with random back-pressure and requester gaps.
        apply_reset();
        tmo_seen = 0;
        for (int n = 0; n < 4000; n++) begin
            tx_ready = ($urandom_range(0, 99) < 60);
            arb_en   = ($urandom_range(0, 99) < 90);
            for (int r = 0; r < NUM_REQ; r++) begin
                src_en[r] = ($urandom_range(0, 99) < 85);
                if (src_q[r].size() < 3) push_rand_line(r);
            end
            step();
        end
        check("rand_no_timeout", 32'(tmo_seen), 32'd0);
        check("rand_lines_progress", 32'(lines_done > 16'd100), 32'd1);

        // Reset in the middle of a line, then requests pending with arb_en low.
        for (int r = 0; r < NUM_REQ; r++) begin
            src_q[r].delete();
            src_en[r] = 1'b1;
        end
        apply_reset();
        push_str(0, "MIDLINE\n");
        arb_en = 1'b1; tx_ready = 1'b1;
        run(4);
        tx_ready = 1'b0;
        push_str(2, "Q\n");
        run(2);
        check("mid_locked", 32'(grant_active), 32'd1);
        apply_reset();
        grants_seen.delete();
        tx_ready = 1'b1;
        run(10);
        check("mid_no_grant", 32'(grants_seen.size()), 32'd0);
        check("mid_idle", 32'(grant_active), 32'd0);
        arb_en = 1'b1;
        run(20);
        check("mid_first_grant", 32'(grant_at(0)), 32'd0);
        check("mid_second_grant", 32'(grant_at(1)), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
